word_tokenizer: RTL and testbench
=================================

WORD_TOKENIZER -- requirements
Module: word_tokenizer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL be the maximum word length in characters.
REQ-002 Parameter DATA, default 32, SHALL be the numeric literal width in bits; character width SHALL be fixed at 8 and WIDTH_BITS SHALL equal clog2(WIDTH)+1.
REQ-003 i_clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 i_reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 i_valid  in  1  SHALL qualify i_data; one byte per cycle, back-to-back allowed.
REQ-006 i_data  in  8  SHALL carry the received character (UART byte).
REQ-007 o_word  out  8 x WIDTH array  SHALL hold the last emitted word, character 0 first.
REQ-008 o_len  out  WIDTH_BITS  SHALL hold the character count of o_word.
REQ-009 o_valid  out  1  SHALL be a one-cycle strobe marking a new word (drives the opcode stage's i_en).
REQ-010 o_is_num  out  1  SHALL flag that o_word is a decimal literal.
REQ-011 o_num  out  DATA  SHALL hold the literal's two's-complement value.
REQ-012 o_err  out  1  SHALL be a one-cycle strobe marking a discarded over-length word.

Function
REQ-013 Delimiters SHALL be 0x20, 0x09, 0x0A, 0x0D; every other byte SHALL be a word character.
REQ-014 FSM SHALL have states SKIP, ACCUM and DISCARD.
REQ-015 SKIP: delimiter -> stay; character -> store at index 0, len=1, go ACCUM.
REQ-016 ACCUM: character with len<WIDTH -> store at index len, len+1; character with len==WIDTH -> go DISCARD.
REQ-017 ACCUM on delimiter SHALL go SKIP and, on the next cycle, present o_valid=1 with o_word/o_len/o_is_num/o_num updated (latency 1 cycle from the delimiter byte).
REQ-018 DISCARD: character -> stay; delimiter -> go SKIP and pulse o_err=1 for one cycle next cycle with o_valid=0.
REQ-019 Emitted o_word entries at index >= o_len SHALL be 0x00.
REQ-020 o_word, o_len, o_is_num and o_num SHALL stay stable between o_valid strobes.
REQ-021 A word of exactly WIDTH characters SHALL emit normally.
REQ-022 o_is_num SHALL be 1 iff the word is one or more '0'-'9' digits, optionally preceded by a single leading '-'; "-" alone SHALL give o_is_num=0.
REQ-023 The value SHALL accumulate as v = v*10 + digit modulo 2^DATA; o_num SHALL be -v (mod 2^DATA) when the leading '-' is present, else v.
REQ-024 When o_is_num=0, o_num SHALL be 0.
REQ-025 A character arriving in the same cycle o_valid or o_err is asserted SHALL be accepted with no loss.
REQ-026 Cycles with i_valid=0 SHALL not change state; words SHALL span idle gaps.

Reset
REQ-027 Asserting i_reset SHALL immediately force state SKIP, clear len and the buffer, and drive o_word all 0x00, o_len=0, o_valid=0, o_is_num=0, o_num=0, o_err=0.
REQ-028 A partial word interrupted by reset SHALL be dropped, with no o_valid or o_err.

Verification
REQ-029 "DUP " back-to-back -> o_valid for one cycle, one cycle after the space; o_len=3; o_word[0..2]="D","U","P"; o_word[3..]=0; o_is_num=0.
REQ-030 "-42\n" -> o_valid; o_len=3; o_is_num=1; o_num=32'hFFFFFFD6. "- " -> o_len=1, o_is_num=0, o_num=0. "4294967297 " -> o_num=1.
REQ-031 32 x 'A' then space -> o_valid, o_len=32. 33 x 'A' then space -> o_err pulse, no o_valid; following "+ " -> o_valid, o_len=1, o_word[0]="+".
REQ-032 "  \t\r\n" -> no strobes. "1 2 " on consecutive cycles -> two o_valid pulses two cycles apart, o_num=1 then 2.
REQ-033 "SW", then i_reset pulse between clock edges, then "AP " -> no output before "AP"; then o_valid with o_len=2, o_word="A","P".
REQ-034 "S", 5 idle cycles, "WAP " -> single o_valid, o_len=4, o_word="SWAP".

Source files
------------

// File: rtl/word_tokenizer_if.sv
// Byte-stream in / word-token out bundle between the UART receiver and the opcode stage.
// The tokenizer sits on the slave side; the byte source and the token consumer sit on the master side.
interface word_tokenizer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DATA  = 32
);
    localparam int unsigned WIDTH_BITS = $clog2(WIDTH) + 1;

    logic                       i_valid;
    logic [7:0]                 i_data;
    logic [WIDTH-1:0][7:0]      o_word;
    logic [WIDTH_BITS-1:0]      o_len;
    logic                       o_valid;
    logic                       o_is_num;
    logic [DATA-1:0]            o_num;
    logic                       o_err;

    modport master (
        output i_valid, i_data,
        input  o_word, o_len, o_valid, o_is_num, o_num, o_err
    );

    modport slave (
        input  i_valid, i_data,
        output o_word, o_len, o_valid, o_is_num, o_num, o_err
    );
endinterface

// File: rtl/word_tokenizer.sv
// Splits a byte stream into whitespace-delimited words, flags decimal literals and their value,
// and drops words longer than WIDTH characters with an error strobe.
module word_tokenizer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DATA  = 32
) (
    input logic           i_clk,
    input logic           i_reset,
    word_tokenizer_if.slave bus
);
    localparam int unsigned WIDTH_BITS = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StSkip, StAccum, StDiscard} state_e;

    state_e                  state_q, state_d;
    logic [WIDTH_BITS-1:0]   len_q, len_d;
    logic [WIDTH-1:0][7:0]   buf_q, buf_d;
    logic                    neg_q, neg_d;
    logic                    num_ok_q, num_ok_d;
    logic                    has_digit_q, has_digit_d;
    logic [DATA-1:0]         acc_q, acc_d;

    logic [WIDTH-1:0][7:0]   word_q, word_d;
    logic [WIDTH_BITS-1:0]   out_len_q, out_len_d;
    logic                    is_num_q, is_num_d;
    logic [DATA-1:0]         num_q, num_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;

    logic                    is_delim;
    logic                    is_digit;
    logic [DATA-1:0]         digit_val;
    logic                    word_is_num;

    always_comb begin
        is_delim  = (bus.i_data == 8'h20) || (bus.i_data == 8'h09) ||
                    (bus.i_data == 8'h0A) || (bus.i_data == 8'h0D);
        is_digit  = (bus.i_data >= 8'h30) && (bus.i_data <= 8'h39);
        digit_val = DATA'(bus.i_data - 8'h30);
        word_is_num = num_ok_q && has_digit_q;
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        buf_d       = buf_q;
        neg_d       = neg_q;
        num_ok_d    = num_ok_q;
        has_digit_d = has_digit_q;
        acc_d       = acc_q;
        word_d      = word_q;
        out_len_d   = out_len_q;
        is_num_d    = is_num_q;
        num_d       = num_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        if (bus.i_valid) begin
            case (state_q)
                StSkip: begin
                    if (!is_delim) begin
                        // Clearing on word start keeps entries past len at 0x00 when emitted.
                        buf_d       = '0;
                        buf_d[0]    = bus.i_data;
                        len_d       = WIDTH_BITS'(1);
                        state_d     = StAccum;
                        neg_d       = (bus.i_data == 8'h2D);
                        num_ok_d    = (bus.i_data == 8'h2D) || is_digit;
                        has_digit_d = is_digit;
                        acc_d       = is_digit ? digit_val : '0;
                    end
                end
                StAccum: begin
                    if (is_delim) begin
                        state_d   = StSkip;
                        valid_d   = 1'b1;
                        word_d    = buf_q;
                        out_len_d = len_q;
                        is_num_d  = word_is_num;
                        num_d     = !word_is_num ? '0 : (neg_q ? -acc_q : acc_q);
                    end else if (len_q == WIDTH_BITS'(WIDTH)) begin
                        state_d = StDiscard;
                    end else begin
                        for (int i = 0; i < int'(WIDTH); i++) begin
                            if (len_q == WIDTH_BITS'(i)) buf_d[i] = bus.i_data;
                        end
                        len_d = len_q + WIDTH_BITS'(1);
                        if (is_digit) begin
                            acc_d       = acc_q * DATA'(10) + digit_val;
                            has_digit_d = 1'b1;
                        end else begin
                            num_ok_d = 1'b0;
                        end
                    end
                end
                StDiscard: begin
                    if (is_delim) begin
                        state_d = StSkip;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = StSkip;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StSkip;
            len_q       <= '0;
            buf_q       <= '0;
            neg_q       <= 1'b0;
            num_ok_q    <= 1'b0;
            has_digit_q <= 1'b0;
            acc_q       <= '0;
            word_q      <= '0;
            out_len_q   <= '0;
            is_num_q    <= 1'b0;
            num_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            buf_q       <= buf_d;
            neg_q       <= neg_d;
            num_ok_q    <= num_ok_d;
            has_digit_q <= has_digit_d;
            acc_q       <= acc_d;
            word_q      <= word_d;
            out_len_q   <= out_len_d;
            is_num_q    <= is_num_d;
            num_q       <= num_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_word   = word_q;
    assign bus.o_len    = out_len_q;
    assign bus.o_is_num = is_num_q;
    assign bus.o_num    = num_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_err    = err_q;
endmodule

// File: tb/tb_word_tokenizer.sv
// Directed bench for word_tokenizer: inputs change and outputs are sampled on the falling edge.
module tb_word_tokenizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;
    int   nvalid = 0;
    int   nstrb_err = 0;
    int   snap_v;
    int   snap_e;

    always #5 clk = ~clk;

    word_tokenizer_if #(.WIDTH(32), .DATA(32)) bus ();

    word_tokenizer #(.WIDTH(32), .DATA(32)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    // Strobe tally; at a rising edge the registers still show the cycle just ended.
    always @(posedge clk) begin
        if (bus.o_valid) nvalid <= nvalid + 1;
        if (bus.o_err) nstrb_err <= nstrb_err + 1;
    end

    function automatic logic [255:0] mkword(input string s);
        logic [31:0][7:0] w;
        w = '0;
        for (int i = 0; i < s.len(); i++) w[i] = s[i];
        return w;
    endfunction

    function automatic logic [255:0] mkrep(input logic [7:0] c, input int n);
        logic [31:0][7:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[i] = c;
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        bus.i_valid = 1'b1;
        bus.i_data  = c;
        @(negedge clk);
    endtask

    task automatic sendstr(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_err", 64'(bus.o_err), 64'd0);
        check("rst_len", 64'(bus.o_len), 64'd0);
        check("rst_isnum", 64'(bus.o_is_num), 64'd0);
        check("rst_num", 64'(bus.o_num), 64'd0);
        checkw("rst_word", bus.o_word, 256'd0);
        rst = 1'b0;
        @(negedge clk);

        // "DUP " with latency check and stability afterwards
        sendstr("DUP");
        check("dup_novalid_early", 64'(bus.o_valid), 64'd0);
        send(8'h20);
        check("dup_valid", 64'(bus.o_valid), 64'd1);
        check("dup_len", 64'(bus.o_len), 64'd3);
        checkw("dup_word", bus.o_word, mkword("DUP"));
        check("dup_isnum", 64'(bus.o_is_num), 64'd0);
        check("dup_num", 64'(bus.o_num), 64'd0);
        idle(1);
        check("dup_strobe_1cyc", 64'(bus.o_valid), 64'd0);
        check("dup_len_stable", 64'(bus.o_len), 64'd3);
        checkw("dup_word_stable", bus.o_word, mkword("DUP"));

        sendstr("-42");
        send(8'h0A);
        check("neg_valid", 64'(bus.o_valid), 64'd1);
        check("neg_len", 64'(bus.o_len), 64'd3);
        check("neg_isnum", 64'(bus.o_is_num), 64'd1);
        check("neg_num", 64'(bus.o_num), 64'hFFFF_FFD6);

        sendstr("- ");
        check("dash_valid", 64'(bus.o_valid), 64'd1);
        check("dash_len", 64'(bus.o_len), 64'd1);
        check("dash_isnum", 64'(bus.o_is_num), 64'd0);
        check("dash_num", 64'(bus.o_num), 64'd0);
        checkw("dash_word", bus.o_word, mkword("-"));

        sendstr("4294967297 ");
        check("wrap_valid", 64'(bus.o_valid), 64'd1);
        check("wrap_len", 64'(bus.o_len), 64'd10);
        check("wrap_isnum", 64'(bus.o_is_num), 64'd1);
        check("wrap_num", 64'(bus.o_num), 64'd1);

        // Exactly WIDTH characters emits; one more is discarded
        repeat (32) send(8'h41);
        send(8'h20);
        check("w32_valid", 64'(bus.o_valid), 64'd1);
        check("w32_len", 64'(bus.o_len), 64'd32);
        checkw("w32_word", bus.o_word, mkrep(8'h41, 32));
        repeat (33) send(8'h41);
        send(8'h20);
        check("w33_err", 64'(bus.o_err), 64'd1);
        check("w33_novalid", 64'(bus.o_valid), 64'd0);
        check("w33_len_kept", 64'(bus.o_len), 64'd32);
        send(8'h2B);
        check("w33_err_1cyc", 64'(bus.o_err), 64'd0);
        send(8'h20);
        check("plus_valid", 64'(bus.o_valid), 64'd1);
        check("plus_len", 64'(bus.o_len), 64'd1);
        checkw("plus_word", bus.o_word, mkword("+"));

        idle(2);
        snap_v = nvalid;
        snap_e = nstrb_err;
        send(8'h20); send(8'h20); send(8'h09); send(8'h0D); send(8'h0A);
        idle(2);
        check("ws_no_valid", 64'(nvalid - snap_v), 64'd0);
        check("ws_no_err", 64'(nstrb_err - snap_e), 64'd0);

        send(8'h31);
        send(8'h20);
        check("one_valid", 64'(bus.o_valid), 64'd1);
        check("one_num", 64'(bus.o_num), 64'd1);
        send(8'h32);
        check("gap_novalid", 64'(bus.o_valid), 64'd0);
        send(8'h20);
        check("two_valid", 64'(bus.o_valid), 64'd1);
        check("two_num", 64'(bus.o_num), 64'd2);
        check("two_isnum", 64'(bus.o_is_num), 64'd1);

        // Reset between edges drops the partial word and clears outputs at once
        idle(2);
        snap_v = nvalid;
        snap_e = nstrb_err;
        sendstr("SW");
        bus.i_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_len", 64'(bus.o_len), 64'd0);
        check("arst_isnum", 64'(bus.o_is_num), 64'd0);
        check("arst_num", 64'(bus.o_num), 64'd0);
        checkw("arst_word", bus.o_word, 256'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        sendstr("AP");
        check("ap_novalid_early", 64'(nvalid - snap_v), 64'd0);
        send(8'h20);
        check("ap_valid", 64'(bus.o_valid), 64'd1);
        check("ap_len", 64'(bus.o_len), 64'd2);
        checkw("ap_word", bus.o_word, mkword("AP"));
        idle(2);
        check("ap_single", 64'(nvalid - snap_v), 64'd1);
        check("ap_no_err", 64'(nstrb_err - snap_e), 64'd0);

        // Idle gaps inside a word
        snap_v = nvalid;
        send(8'h53);
        idle(5);
        sendstr("WAP");
        send(8'h20);
        check("swap_valid", 64'(bus.o_valid), 64'd1);
        check("swap_len", 64'(bus.o_len), 64'd4);
        checkw("swap_word", bus.o_word, mkword("SWAP"));
        idle(2);
        check("swap_single", 64'(nvalid - snap_v), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
